// File: rtl/cache_tag_memory_nway.sv
// N-way set-associative tag store: valid/dirty/tag per way, true-LRU age counters,
// combinational lookup and registered load / touch / dirty-mark / invalidate.
module cache_tag_memory_nway #(
  parameter int INDEX_W   = 6,
  parameter int TAG_W     = 6,
  parameter int WAYS_LOG2 = 3
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [INDEX_W-1:0]   ADDR_INDEX,
  input  logic [TAG_W-1:0]     ADDR_TAG,
  input  logic                 SIG_LRU,
  input  logic                 SIG_LOAD,
  input  logic                 SIG_DIRTY,
  input  logic                 SIG_INVAL,
  output logic [WAYS_LOG2-1:0] CHANNEL,
  output logic                 HIT,
  output logic                 VICTIM_VALID,
  output logic                 VICTIM_DIRTY,
  output logic [TAG_W-1:0]     VICTIM_TAG
);

  localparam int SETS = 2 ** INDEX_W;
  localparam int WAYS = 2 ** WAYS_LOG2;
  localparam logic [WAYS_LOG2-1:0] CNT_OLDEST = WAYS_LOG2'(WAYS - 1);
  localparam logic [WAYS_LOG2-1:0] CNT_ONE    = WAYS_LOG2'(1);
  localparam logic [WAYS_LOG2-1:0] CNT_ZERO   = WAYS_LOG2'(0);

  logic                 r_valid [0:SETS-1][0:WAYS-1];
  logic                 r_dirty [0:SETS-1][0:WAYS-1];
  logic [TAG_W-1:0]     r_tag   [0:SETS-1][0:WAYS-1];
  logic [WAYS_LOG2-1:0] r_cnt   [0:SETS-1][0:WAYS-1];

  logic                 w_hit;
  logic                 w_inv_found;
  logic [WAYS_LOG2-1:0] w_hit_way;
  logic [WAYS_LOG2-1:0] w_inv_way;
  logic [WAYS_LOG2-1:0] w_old_way;
  logic [WAYS_LOG2-1:0] w_channel;
  logic [WAYS_LOG2-1:0] w_cnt_sel;
  logic                 w_victim_valid;
  logic                 w_do_inval;
  logic                 w_do_load;
  logic                 w_do_mark;
  logic                 w_do_touch;
  logic [WAYS_LOG2-1:0] w_cnt_next [0:WAYS-1];

  // Tag compare and replacement search; descending scan so the lowest way wins.
  always_comb begin
    w_hit       = 1'b0;
    w_inv_found = 1'b0;
    w_hit_way   = CNT_ZERO;
    w_inv_way   = CNT_ZERO;
    w_old_way   = CNT_ZERO;
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_hit     = w_hit | (r_valid[ADDR_INDEX][w] && (r_tag[ADDR_INDEX][w] == ADDR_TAG));
      w_hit_way = (r_valid[ADDR_INDEX][w] && (r_tag[ADDR_INDEX][w] == ADDR_TAG)) ?
                  WAYS_LOG2'(w) : w_hit_way;
      w_inv_found = w_inv_found | !r_valid[ADDR_INDEX][w];
      w_inv_way   = !r_valid[ADDR_INDEX][w] ? WAYS_LOG2'(w) : w_inv_way;
      w_old_way   = (r_cnt[ADDR_INDEX][w] == CNT_OLDEST) ? WAYS_LOG2'(w) : w_old_way;
    end
  end

  assign w_channel      = w_hit ? w_hit_way : (w_inv_found ? w_inv_way : w_old_way);
  assign w_victim_valid = !w_hit && !w_inv_found;

  assign CHANNEL      = w_channel;
  assign HIT          = w_hit;
  assign VICTIM_VALID = w_victim_valid;
  assign VICTIM_DIRTY = w_victim_valid && r_dirty[ADDR_INDEX][w_channel];
  assign VICTIM_TAG   = w_victim_valid ? r_tag[ADDR_INDEX][w_channel] : {TAG_W{1'b0}};

  // Invalidate on hit pre-empts everything; a touch needs a way that holds (or is receiving) the line.
  assign w_do_inval = SIG_INVAL && w_hit;
  assign w_do_load  = SIG_LOAD && !w_hit;
  assign w_do_mark  = SIG_DIRTY && w_hit && !SIG_INVAL;
  assign w_do_touch = SIG_LRU && (w_hit || SIG_LOAD) && !w_do_inval;
  assign w_cnt_sel  = r_cnt[ADDR_INDEX][w_channel];

  // Age update keeps the counters of the addressed set a permutation of 0..WAYS-1.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      w_cnt_next[w] = r_cnt[ADDR_INDEX][w];
      if (w_do_inval) begin
        if (WAYS_LOG2'(w) == w_channel) begin
          w_cnt_next[w] = CNT_OLDEST;
        end else if (r_cnt[ADDR_INDEX][w] > w_cnt_sel) begin
          w_cnt_next[w] = r_cnt[ADDR_INDEX][w] - CNT_ONE;
        end else begin
          w_cnt_next[w] = r_cnt[ADDR_INDEX][w];
        end
      end else if (w_do_touch) begin
        if (WAYS_LOG2'(w) == w_channel) begin
          w_cnt_next[w] = CNT_ZERO;
        end else if (r_cnt[ADDR_INDEX][w] < w_cnt_sel) begin
          w_cnt_next[w] = r_cnt[ADDR_INDEX][w] + CNT_ONE;
        end else begin
          w_cnt_next[w] = r_cnt[ADDR_INDEX][w];
        end
      end else begin
        w_cnt_next[w] = r_cnt[ADDR_INDEX][w];
      end
    end
  end

  // Tag/state storage; reset wins over any update sampled on the same edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_tag[s][w]   <= {TAG_W{1'b0}};
          r_cnt[s][w]   <= WAYS_LOG2'(w);
        end
      end
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        r_cnt[ADDR_INDEX][w] <= w_cnt_next[w];
      end
      if (w_do_inval) begin
        r_valid[ADDR_INDEX][w_channel] <= 1'b0;
        r_dirty[ADDR_INDEX][w_channel] <= 1'b0;
      end else if (w_do_load) begin
        r_tag[ADDR_INDEX][w_channel]   <= ADDR_TAG;
        r_valid[ADDR_INDEX][w_channel] <= 1'b1;
        r_dirty[ADDR_INDEX][w_channel] <= SIG_DIRTY;
      end else if (w_do_mark) begin
        r_dirty[ADDR_INDEX][w_channel] <= 1'b1;
      end
    end
  end

endmodule
